// File: rtl/dec_fpr_bank_ctl_if.sv
// -----------------------------------------------------------------------------
// dec_fpr_bank_ctl_if
// Bus bundle for the banked FP register file.
//   master : read/write requester and bank-switch requester (decode stage / bench)
//   slave  : the register file controller itself
// Signals:
//   rden/raddr/rd            read ports (port p: raddr[5p+4:5p], rd[FLEN*p +: FLEN])
//   wen/waddr/wd/wsp         write ports, wsp flags a single-precision write
//   bank_req_valid/id/copy   bank-switch request, bank_req_ready handshake back
//   cur_bank/busy/dirty      active bank, copy-in-progress, active bank dirty bits
//   dirty_clr                clear the active bank's dirty bits
//   err_wr_busy              sticky: a write was dropped while copying
// -----------------------------------------------------------------------------
interface dec_fpr_bank_ctl_if #(
    parameter int FLEN   = 64,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 3,
    parameter int BANK_W = 1
);
    logic [NUM_RD-1:0]      rden;
    logic [NUM_RD*5-1:0]    raddr;
    logic [NUM_RD*FLEN-1:0] rd;
    logic [NUM_WR-1:0]      wen;
    logic [NUM_WR*5-1:0]    waddr;
    logic [NUM_WR*FLEN-1:0] wd;
    logic [NUM_WR-1:0]      wsp;
    logic                   bank_req_valid;
    logic [BANK_W-1:0]      bank_req_id;
    logic                   bank_req_copy;
    logic                   bank_req_ready;
    logic [BANK_W-1:0]      cur_bank;
    logic                   busy;
    logic [31:0]            dirty;
    logic                   dirty_clr;
    logic                   err_wr_busy;

    modport master (
        output rden, raddr, wen, waddr, wd, wsp,
        output bank_req_valid, bank_req_id, bank_req_copy, dirty_clr,
        input  rd, bank_req_ready, cur_bank, busy, dirty, err_wr_busy
    );

    modport slave (
        input  rden, raddr, wen, waddr, wd, wsp,
        input  bank_req_valid, bank_req_id, bank_req_copy, dirty_clr,
        output rd, bank_req_ready, cur_bank, busy, dirty, err_wr_busy
    );
endinterface

// File: rtl/dec_fpr_bank_ctl.sv
// -----------------------------------------------------------------------------
// dec_fpr_bank_ctl
// Banked floating-point register file for the decode stage.
//   - BANKS x 32 registers of FLEN bits; all reads/writes target cur_bank.
//   - Combinational reads without write bypass; writes commit at the edge.
//   - Single-precision writes are NaN-boxed when NANBOX and FLEN == 64.
//   - Per-register dirty bits per bank, clearable for the active bank.
//   - Bank switch via request/ready; optional copy of the active bank into
//     the target bank (one register per cycle, 32 cycles) before switching.
// Ports:
//   clk        clock
//   rst_l      asynchronous active-low reset
//   scan_mode  scan mode (no functional effect in this block)
//   bus        dec_fpr_bank_ctl_if.slave (read/write ports, bank handshake,
//              dirty vector, error flag)
// -----------------------------------------------------------------------------
module dec_fpr_bank_ctl #(
    parameter int FLEN   = 64,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 3,
    parameter int BANKS  = 2,
    parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
    parameter int NANBOX = 1
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 scan_mode,
    dec_fpr_bank_ctl_if.slave    bus
);

    localparam bit              BOX_EN = (NANBOX != 0) && (FLEN == 64);
    localparam logic [BANK_W:0] NBANKS = BANKS[BANK_W:0];

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } state_e;

    // Upper half forced to all ones for a single-precision write (NaN-box).
    function automatic logic [FLEN-1:0] nanbox_f(input logic [FLEN-1:0] data,
                                                 input logic            sp);
        logic [FLEN-1:0] res;
        res = data;
        if (BOX_EN && sp) begin
            for (int b = 32; b < FLEN; b++) begin
                res[b] = 1'b1;
            end
        end else begin
            res = data;
        end
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [FLEN-1:0]   regs_q  [BANKS][32];
    logic [FLEN-1:0]   regs_d  [BANKS][32];
    logic [31:0]       dirty_q [BANKS];
    logic [31:0]       dirty_d [BANKS];
    logic [BANK_W-1:0] cur_bank_q, cur_bank_d;
    logic [BANK_W-1:0] src_q, src_d;
    logic [BANK_W-1:0] dst_q, dst_d;
    logic [4:0]        idx_q, idx_d;
    logic              err_q, err_d;

    logic [NUM_RD*FLEN-1:0] rd_s;
    logic                   req_id_ok_s;
    logic                   unused_scan_s;

    assign unused_scan_s = scan_mode;

    // Out-of-range bank ids are not valid targets.
    assign req_id_ok_s = ({1'b0, bus.bank_req_id} < NBANKS);

    // Next-state: FSM, storage writes, dirty tracking, copy engine.
    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        dirty_d    = dirty_q;
        cur_bank_d = cur_bank_q;
        src_d      = src_q;
        dst_d      = dst_q;
        idx_d      = idx_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.dirty_clr) begin
                    dirty_d[cur_bank_q] = 32'h0000_0000;
                end else begin
                    dirty_d[cur_bank_q] = dirty_q[cur_bank_q];
                end

                // Ascending port order: the highest port index wins on a clash,
                // and a write always re-sets its dirty bit after any clear.
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.wen[k]) begin
                        regs_d[cur_bank_q][bus.waddr[k*5 +: 5]] =
                            nanbox_f(bus.wd[k*FLEN +: FLEN], bus.wsp[k]);
                        dirty_d[cur_bank_q][bus.waddr[k*5 +: 5]] = 1'b1;
                    end else begin
                        // port idle this cycle: nothing to commit
                    end
                end

                // Writes above use the old cur_bank, so an accept-cycle write
                // lands in the bank being left.
                if (bus.bank_req_valid && req_id_ok_s) begin
                    if (bus.bank_req_copy && (bus.bank_req_id != cur_bank_q)) begin
                        src_d   = cur_bank_q;
                        dst_d   = bus.bank_req_id;
                        idx_d   = 5'd0;
                        state_d = ST_COPY;
                    end else begin
                        cur_bank_d = bus.bank_req_id;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COPY: begin
                regs_d[dst_q][idx_q]  = regs_q[src_q][idx_q];
                dirty_d[dst_q][idx_q] = 1'b1;
                idx_d                 = idx_q + 5'd1;

                if (|bus.wen) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end

                if (idx_q == 5'd31) begin
                    cur_bank_d = dst_q;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_COPY;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    // State, storage and dirty registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= ST_IDLE;
            regs_q     <= '{default: {FLEN{1'b0}}};
            dirty_q    <= '{default: 32'h0000_0000};
            cur_bank_q <= {BANK_W{1'b0}};
            src_q      <= {BANK_W{1'b0}};
            dst_q      <= {BANK_W{1'b0}};
            idx_q      <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            dirty_q    <= dirty_d;
            cur_bank_q <= cur_bank_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
        end
    end

    // Combinational read ports; reads are blanked while a copy is running.
    always_comb begin
        rd_s = {(NUM_RD*FLEN){1'b0}};
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rden[p] && (state_q == ST_IDLE)) begin
                rd_s[p*FLEN +: FLEN] = regs_q[cur_bank_q][bus.raddr[p*5 +: 5]];
            end else begin
                rd_s[p*FLEN +: FLEN] = {FLEN{1'b0}};
            end
        end
    end

    assign bus.rd             = rd_s;
    assign bus.bank_req_ready = (state_q == ST_IDLE);
    assign bus.busy           = (state_q == ST_COPY);
    assign bus.cur_bank       = cur_bank_q;
    assign bus.dirty          = dirty_q[cur_bank_q];
    assign bus.err_wr_busy    = err_q;

endmodule

// File: tb/tb_dec_fpr_bank_ctl.sv
// -----------------------------------------------------------------------------
// tb_dec_fpr_bank_ctl
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences (copy switch, write during copy, reset mid-copy, plain switch,
// invalid id) and a randomized phase, all checked against a bank-level
// reference model that performs a bank copy as one bulk transfer when the
// 32-cycle busy window ends.
// -----------------------------------------------------------------------------
module tb_dec_fpr_bank_ctl;
    localparam int FLEN   = 64;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 3;
    localparam int BANKS  = 3;
    localparam int BANK_W = 2;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic scan_mode = 1'b0;

    dec_fpr_bank_ctl_if #(.FLEN(FLEN), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BANK_W(BANK_W)) bus ();

    dec_fpr_bank_ctl #(
        .FLEN(FLEN), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
        .BANKS(BANKS), .BANK_W(BANK_W), .NANBOX(1)
    ) dut (
        .clk(clk),
        .rst_l(rst_l),
        .scan_mode(scan_mode),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [63:0] mreg   [BANKS][32];
    logic [31:0] mdirty [BANKS];
    int          mbank;
    int          mdst;
    int          copy_left;
    logic        merr;
    logic        last_busy;

    typedef struct {
        logic [2:0]   wen;
        logic [14:0]  waddr;
        logic [191:0] wd;
        logic [2:0]   wsp;
        logic         dirty_clr;
        logic [4:0]   raddr0;
        logic [63:0]  exp_rd0;
        logic [31:0]  exp_dirty;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fp_store(input logic [63:0] d, input logic sp);
        return sp ? {32'hFFFF_FFFF, d[31:0]} : d;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BANKS; b++) begin
            mdirty[b] = 32'h0;
            for (int r = 0; r < 32; r++) mreg[b][r] = 64'h0;
        end
        mbank = 0;
        mdst = 0;
        copy_left = 0;
        merr = 1'b0;
    endtask

    // One clock edge of architectural behaviour, using the inputs currently driven.
    task automatic model_step();
        int id;
        if (copy_left > 0) begin
            if (bus.wen != 3'b000) merr = 1'b1;
            copy_left--;
            if (copy_left == 0) begin
                for (int r = 0; r < 32; r++) mreg[mdst][r] = mreg[mbank][r];
                mdirty[mdst] = 32'hFFFF_FFFF;
                mbank = mdst;
            end
        end else begin
            if (bus.dirty_clr) mdirty[mbank] = 32'h0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wen[k]) begin
                    mreg[mbank][bus.waddr[k*5 +: 5]] = fp_store(bus.wd[k*64 +: 64], bus.wsp[k]);
                    mdirty[mbank][bus.waddr[k*5 +: 5]] = 1'b1;
                end
            end
            id = int'(bus.bank_req_id);
            if (bus.bank_req_valid && id < BANKS) begin
                if (bus.bank_req_copy && id != mbank) begin
                    mdst = id;
                    copy_left = 32;
                end else begin
                    mbank = id;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] exp;
        for (int p = 0; p < NUM_RD; p++) begin
            exp = (copy_left == 0 && bus.rden[p]) ? mreg[mbank][bus.raddr[p*5 +: 5]] : 64'h0;
            check($sformatf("rd%0d", p), bus.rd[p*64 +: 64], exp);
        end
        check("dirty", {32'h0, bus.dirty}, {32'h0, mdirty[mbank]});
        check("cur_bank", {62'h0, bus.cur_bank}, 64'(mbank));
        check("busy", {63'h0, bus.busy}, {63'h0, copy_left != 0});
        check("ready", {63'h0, bus.bank_req_ready}, {63'h0, copy_left == 0});
        check("err_wr_busy", {63'h0, bus.err_wr_busy}, {63'h0, merr});
    endtask

    // Called at a falling edge with inputs already driven; ends at the next falling edge.
    task automatic step();
        #1;
        last_busy = bus.busy;
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rden = 4'b0000;
        bus.raddr = 20'h0;
        bus.wen = 3'b000;
        bus.waddr = 15'h0;
        bus.wd = 192'h0;
        bus.wsp = 3'b000;
        bus.bank_req_valid = 1'b0;
        bus.bank_req_id = 2'd0;
        bus.bank_req_copy = 1'b0;
        bus.dirty_clr = 1'b0;
    endtask

    task automatic read0(input logic [4:0] a);
        bus.rden[0] = 1'b1;
        bus.raddr[4:0] = a;
    endtask

    initial begin
        vecs[0] = '{3'b101, {5'd5, 5'd0, 5'd5}, {64'h1234_5678_3F80_0000, 64'h0, 64'h1111_2222_3333_4444},
                    3'b100, 1'b0, 5'd5, 64'h0, 32'h0000_0000};
        vecs[1] = '{3'b000, 15'h0, 192'h0, 3'b000, 1'b0, 5'd5, 64'hFFFF_FFFF_3F80_0000, 32'h0000_0020};
        vecs[2] = '{3'b010, {5'd0, 5'd3, 5'd0}, {64'h0, 64'h0000_0000_0000_DEAD, 64'h0},
                    3'b000, 1'b0, 5'd3, 64'h0, 32'h0000_0020};
        vecs[3] = '{3'b000, 15'h0, 192'h0, 3'b000, 1'b0, 5'd3, 64'h0000_0000_0000_DEAD, 32'h0000_0028};
        vecs[4] = '{3'b011, {5'd0, 5'd7, 5'd7}, {64'h0, 64'h0123_4567_89AB_CDEF, 64'hAAAA_BBBB_CCCC_DDDD},
                    3'b001, 1'b0, 5'd5, 64'hFFFF_FFFF_3F80_0000, 32'h0000_0028};
        vecs[5] = '{3'b000, 15'h0, 192'h0, 3'b000, 1'b0, 5'd7, 64'h0123_4567_89AB_CDEF, 32'h0000_00A8};
        vecs[6] = '{3'b100, {5'd1, 5'd0, 5'd0}, {64'h0000_0000_4049_0FDB, 64'h0, 64'h0},
                    3'b100, 1'b1, 5'd7, 64'h0123_4567_89AB_CDEF, 32'h0000_00A8};
        vecs[7] = '{3'b000, 15'h0, 192'h0, 3'b000, 1'b0, 5'd1, 64'hFFFF_FFFF_4049_0FDB, 32'h0000_0002};

        // ---------------- reset ----------------
        idle_inputs();
        model_reset();
        rst_l = 1'b0;
        @(negedge clk);
        read0(5'd0);
        #1;
        check("reset_rd0", bus.rd[63:0], 64'h0);
        check("reset_cur_bank", {62'h0, bus.cur_bank}, 64'h0);
        check("reset_dirty", {32'h0, bus.dirty}, 64'h0);
        check("reset_ready", {63'h0, bus.bank_req_ready}, 64'h1);
        check("reset_err", {63'h0, bus.err_wr_busy}, 64'h0);
        @(negedge clk);
        rst_l = 1'b1;

        // ---------------- directed vector table ----------------
        for (int v = 0; v < 8; v++) begin
            idle_inputs();
            bus.wen = vecs[v].wen;
            bus.waddr = vecs[v].waddr;
            bus.wd = vecs[v].wd;
            bus.wsp = vecs[v].wsp;
            bus.dirty_clr = vecs[v].dirty_clr;
            read0(vecs[v].raddr0);
            #1;
            check($sformatf("vec%0d_rd0", v), bus.rd[63:0], vecs[v].exp_rd0);
            check($sformatf("vec%0d_dirty", v), {32'h0, bus.dirty}, {32'h0, vecs[v].exp_dirty});
            step();
        end

        // ---------------- copy switch with a write during copy ----------------
        for (int c = 0; c < 11; c++) begin
            idle_inputs();
            for (int k = 0; k < NUM_WR; k++) begin
                if (c*3 + k < 32) begin
                    bus.wen[k] = 1'b1;
                    bus.waddr[k*5 +: 5] = 5'(c*3 + k);
                    bus.wd[k*64 +: 64] = 64'(c*3 + k + 1);
                end
            end
            step();
        end
        idle_inputs();
        bus.bank_req_valid = 1'b1;
        bus.bank_req_copy = 1'b1;
        bus.bank_req_id = 2'd1;
        step();
        begin
            int busy_cycles;
            busy_cycles = 0;
            for (int i = 0; i < 40; i++) begin
                idle_inputs();
                bus.rden = 4'b1111;
                bus.raddr = 20'($urandom);
                if (i == 5) begin
                    bus.wen = 3'b001;
                    bus.waddr = 15'd2;
                    bus.wd = 192'h77;
                end
                step();
                if (last_busy) busy_cycles++;
                else break;
            end
            check("copy_busy_cycles", 64'(busy_cycles), 64'd32);
        end
        idle_inputs();
        read0(5'd7);
        #1;
        check("copy_cur_bank", {62'h0, bus.cur_bank}, 64'd1);
        check("copy_f7", bus.rd[63:0], 64'd8);
        check("copy_dirty", {32'h0, bus.dirty}, 64'hFFFF_FFFF);
        check("copy_err", {63'h0, bus.err_wr_busy}, 64'd1);
        step();
        idle_inputs();
        bus.dirty_clr = 1'b1;
        step();
        idle_inputs();
        read0(5'd2);
        #1;
        check("clr_dirty", {32'h0, bus.dirty}, 64'h0);
        check("err_sticky", {63'h0, bus.err_wr_busy}, 64'd1);
        check("dropped_write_f2", bus.rd[63:0], 64'd3);
        step();

        // ---------------- reset mid-copy ----------------
        idle_inputs();
        bus.bank_req_valid = 1'b1;
        bus.bank_req_copy = 1'b1;
        bus.bank_req_id = 2'd2;
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        rst_l = 1'b0;
        read0(5'd7);
        #1;
        model_reset();
        check("midrst_rd0", bus.rd[63:0], 64'h0);
        check("midrst_cur_bank", {62'h0, bus.cur_bank}, 64'h0);
        check("midrst_busy", {63'h0, bus.busy}, 64'h0);
        check("midrst_ready", {63'h0, bus.bank_req_ready}, 64'h1);
        check("midrst_err", {63'h0, bus.err_wr_busy}, 64'h0);
        @(negedge clk);
        rst_l = 1'b1;
        idle_inputs();
        bus.bank_req_valid = 1'b1;
        bus.bank_req_id = 2'd2;
        step();
        idle_inputs();
        read0(5'd3);
        #1;
        check("midrst_bank2_cleared", bus.rd[63:0], 64'h0);
        step();
        idle_inputs();
        bus.bank_req_valid = 1'b1;
        bus.bank_req_id = 2'd0;
        step();

        // ---------------- plain switch, accept-cycle write, invalid id ----------------
        idle_inputs();
        bus.wen = 3'b001;
        bus.waddr = 15'd0;
        bus.wd = 192'h55;
        bus.bank_req_valid = 1'b1;
        bus.bank_req_id = 2'd1;
        read0(5'd0);
        step();
        idle_inputs();
        read0(5'd0);
        #1;
        check("plain_cur_bank", {62'h0, bus.cur_bank}, 64'd1);
        check("plain_f0", bus.rd[63:0], 64'h0);
        check("plain_dirty", {32'h0, bus.dirty}, 64'h0);
        step();
        idle_inputs();
        bus.bank_req_valid = 1'b1;
        bus.bank_req_id = 2'd3;
        step();
        idle_inputs();
        #1;
        check("invalid_id_bank", {62'h0, bus.cur_bank}, 64'd1);
        step();
        idle_inputs();
        bus.bank_req_valid = 1'b1;
        bus.bank_req_id = 2'd0;
        step();
        idle_inputs();
        read0(5'd0);
        #1;
        check("old_bank_f0", bus.rd[63:0], 64'h55);
        check("old_bank_dirty", {32'h0, bus.dirty}, 64'h1);
        step();

        // ---------------- randomized phase ----------------
        for (int i = 0; i < 2000; i++) begin
            bus.rden = 4'($urandom);
            bus.raddr = 20'($urandom);
            bus.wen = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
            bus.waddr = 15'($urandom);
            bus.wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            bus.wsp = 3'($urandom);
            bus.bank_req_valid = ($urandom_range(0, 19) == 0);
            bus.bank_req_id = 2'($urandom_range(0, 3));
            bus.bank_req_copy = 1'($urandom);
            bus.dirty_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
